stage4_issue_queue: RTL

In-order issue queue and scheduler between decode and execute in the 4-stage pipeline. It buffers decoded instruction packets written by decode and issues them to execute one per cycle. It reports fullness to the hazard unit and obeys the hazard unit's queue stall/flush controls. It serializes `vsetvl`: once a `vsetvl` issues, nothing further issues until execute reports that it has resolved.

---
 rtl/stage4_issue_queue_if.sv | 31 +++
 rtl/stage4_issue_queue.sv | 87 ++++++++
 2 files changed

// File: rtl/stage4_issue_queue_if.sv
// Decode/hazard/execute-facing bundle of the in-order issue queue.
// master drives writes and hazard controls; slave is the queue itself.
interface stage4_issue_queue_if #(
   parameter int DEPTH   = 4,
   parameter int ENTRY_W = 64
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic               queue_wen;
   logic [ENTRY_W-1:0] wdata;
   logic               w_vsetvl;
   logic               is_queue_full;
   logic               stall_queue;
   logic               flush_queue;
   logic               vsetvl_done;
   logic               issue_valid;
   logic [ENTRY_W-1:0] issue_data;
   logic               issue_vsetvl;
   logic               vl_pending;
   logic [CNT_W-1:0]   count;

   modport master (
      output queue_wen, wdata, w_vsetvl, stall_queue, flush_queue, vsetvl_done,
      input  is_queue_full, issue_valid, issue_data, issue_vsetvl, vl_pending, count
   );

   modport slave (
      input  queue_wen, wdata, w_vsetvl, stall_queue, flush_queue, vsetvl_done,
      output is_queue_full, issue_valid, issue_data, issue_vsetvl, vl_pending, count
   );
endinterface

// File: rtl/stage4_issue_queue.sv
// In-order issue queue: 1-cycle write-to-issue, 1 push + 1 pop per cycle, vsetvl serialised.
// Backpressure: writes while full are dropped (decode must honour is_queue_full); stall holds head.
module stage4_issue_queue #(
   parameter int DEPTH   = 4,
   parameter int ENTRY_W = 64
) (
   input logic                CLK,
   input logic                nRST,
   stage4_issue_queue_if.slave q
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Bit 0 of each entry carries the vsetvl flag.
   logic [ENTRY_W:0]   mem [DEPTH];
   logic [PTR_W-1:0]   head;
   logic [PTR_W-1:0]   tail;
   logic [CNT_W-1:0]   count_q;
   logic               vl_pending_q;

   logic               not_empty;
   logic               full;
   logic               push;
   logic               pop;
   logic               head_vsetvl;
   logic [ENTRY_W-1:0] head_data;

   assign not_empty   = (count_q != '0);
   assign full        = (count_q == CNT_W'(DEPTH));
   assign head_vsetvl = mem[head][0];
   assign head_data   = mem[head][ENTRY_W:1];

   // Push is gated on the registered count only: no credit from a same-cycle pop.
   assign push = q.queue_wen && !full && !q.flush_queue;
   assign pop  = q.issue_valid && !q.stall_queue;

   assign q.issue_valid   = not_empty && !vl_pending_q && !q.flush_queue;
   assign q.issue_data    = not_empty ? head_data : '0;
   assign q.issue_vsetvl  = not_empty ? head_vsetvl : 1'b0;
   assign q.is_queue_full = full;
   assign q.vl_pending    = vl_pending_q;
   assign q.count         = count_q;

   always_ff @(posedge CLK) begin
      if (push) begin
         mem[tail] <= {q.wdata, q.w_vsetvl};
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         head <= '0;
         tail <= '0;
      end else if (q.flush_queue) begin
         head <= '0;
         tail <= '0;
      end else begin
         if (push) tail <= tail + PTR_W'(1);
         if (pop)  head <= head + PTR_W'(1);
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         count_q <= '0;
      end else if (q.flush_queue) begin
         count_q <= '0;
      end else if (push && !pop) begin
         count_q <= count_q + CNT_W'(1);
      end else if (pop && !push) begin
         count_q <= count_q - CNT_W'(1);
      end
   end

   // Set wins over done; the overlap is unreachable because pops stall while pending.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         vl_pending_q <= 1'b0;
      end else if (q.flush_queue) begin
         vl_pending_q <= 1'b0;
      end else if (pop && head_vsetvl) begin
         vl_pending_q <= 1'b1;
      end else if (q.vsetvl_done) begin
         vl_pending_q <= 1'b0;
      end
   end
endmodule
